// File: rtl/display_scan_if.sv
// Bundle between a display scan driver and the logic that feeds it:
// the value/decimal-point inputs plus the registered scan outputs.
interface display_scan_if #(
  parameter int N_DIGITS = 8
);
  localparam int IW = $clog2(N_DIGITS);

  logic [4*N_DIGITS-1:0] value;
  logic                  load;
  logic [N_DIGITS-1:0]   dp_in;
  logic                  blank_lz;
  logic [3:0]            bcd_out;
  logic [N_DIGITS-1:0]   anodes_n;
  logic                  dp_n;
  logic [IW-1:0]         digit_idx;

  modport master (
    output value, load, dp_in, blank_lz,
    input  bcd_out, anodes_n, dp_n, digit_idx
  );

  modport slave (
    input  value, load, dp_in, blank_lz,
    output bcd_out, anodes_n, dp_n, digit_idx
  );
endinterface

// File: rtl/display_scan_driver.sv
// Time-multiplexed scan driver for a common-anode 7-segment display with
// frame-coherent value updates, per-slot dead time and leading-zero blanking.
module display_scan_driver #(
  parameter int N_DIGITS        = 8,
  parameter int TICKS_PER_DIGIT = 100000,
  parameter int DEAD_CYCLES     = 1000
) (
  input logic         clk,
  input logic         reset_n,
  display_scan_if.slave bus
);
  localparam int IW = $clog2(N_DIGITS);
  localparam int CW = $clog2(TICKS_PER_DIGIT);
  localparam logic [CW-1:0] SLOT_LAST = CW'(TICKS_PER_DIGIT - 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);

  typedef enum logic {DEAD, ON} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [4*N_DIGITS-1:0] pending;
  logic [N_DIGITS-1:0]   pending_dp;
  logic                  pending_valid;
  logic [4*N_DIGITS-1:0] shadow;
  logic [N_DIGITS-1:0]   shadow_dp;
  logic [3:0]            bcd_q;
  logic [N_DIGITS-1:0]   an_q;
  logic                  dpn_q;

  logic                  slot_end;
  logic                  frame_end;
  logic [IW-1:0]         idx_nxt;
  logic [4*N_DIGITS-1:0] shadow_nxt;
  logic [N_DIGITS-1:0]   lz;
  logic                  run_zero;
  logic                  lit;
  logic [N_DIGITS-1:0]   on_mask;

  always_comb begin
    slot_end   = (cnt == SLOT_LAST);
    frame_end  = slot_end && (idx == IDX_LAST);
    idx_nxt    = frame_end ? '0 : idx + 1'b1;
    // The first digit of a new frame must already come from the transferred value.
    shadow_nxt = (frame_end && pending_valid) ? pending : shadow;
    run_zero   = 1'b1;
    lz         = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      run_zero = run_zero && (shadow[4*k +: 4] == 4'd0);
      lz[k]    = run_zero;
    end
    lit     = !(bus.blank_lz && (idx != '0) && lz[idx] && !shadow_dp[idx]);
    on_mask = '1;
    for (int k = 0; k < N_DIGITS; k++) begin
      on_mask[k] = !(lit && (idx == IW'(k)));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= DEAD;
      cnt           <= '0;
      idx           <= '0;
      pending       <= '0;
      pending_dp    <= '0;
      pending_valid <= 1'b0;
      shadow        <= '0;
      shadow_dp     <= '0;
      bcd_q         <= 4'd0;
      an_q          <= '1;
      dpn_q         <= 1'b1;
    end else begin
      if (bus.load) begin
        pending       <= bus.value;
        pending_dp    <= bus.dp_in;
        pending_valid <= 1'b1;
      end else if (frame_end) begin
        pending_valid <= 1'b0;
      end
      if (frame_end && pending_valid) begin
        shadow    <= pending;
        shadow_dp <= pending_dp;
      end

      if (slot_end) begin
        cnt   <= '0;
        state <= DEAD;
        idx   <= idx_nxt;
        an_q  <= '1;
        dpn_q <= 1'b1;
        bcd_q <= shadow_nxt[{idx_nxt, 2'b00} +: 4];
      end else begin
        cnt <= cnt + 1'b1;
        case (state)
          DEAD: if (cnt == DEAD_LAST) begin
            state <= ON;
            an_q  <= on_mask;
            dpn_q <= ~shadow_dp[idx];
          end
          ON: ;
          default: state <= DEAD;
        endcase
      end
    end
  end

  assign bus.bcd_out   = bcd_q;
  assign bus.anodes_n  = an_q;
  assign bus.dp_n      = dpn_q;
  assign bus.digit_idx = idx;
endmodule
